// File: rtl/alu_seq_if.sv
// ALU-side bus of the micro-sequencer: operands/opcode out, result and flag back.
// The ALU is purely combinational; the sequencer samples result and flag one cycle after driving operands.
interface alu_seq_if;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [2:0] alu_opcode;
  logic [3:0] alu_result;
  logic       alu_zero;

  modport master (output alu_a, alu_b, alu_opcode, input alu_result, alu_zero);
  modport slave  (input alu_a, alu_b, alu_opcode, output alu_result, alu_zero);
endinterface

// File: rtl/alu_seq_ctrl.sv
// Three-cycle micro-sequencer (FETCH/EXEC/WRITE) driving an external ALU from a 16-word program store.
// Optional watchdog on retired instructions per run is enabled by defining ALU_SEQ_WDOG_EN.
module alu_seq_ctrl #(
  parameter logic [7:0] WDOG_LIMIT = 8'd255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              prog_we,
  input  logic [3:0]        prog_addr,
  input  logic [15:0]       prog_data,
  input  logic [1:0]        dbg_sel,
  output logic [3:0]        dbg_data,
  alu_seq_if.master         alu,
  output logic [3:0]        pc,
  output logic              busy,
  output logic              done,
  output logic [7:0]        retired,
  output logic              err,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_WRITE = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  if (WDOG_LIMIT == 8'd0) begin : g_bad_limit
    $error("alu_seq_ctrl: WDOG_LIMIT must be in 1..255");
  end

  state_t      state, state_n;
  logic [15:0] mem [16];
  logic [3:0]  regs [4];
  logic [15:0] ir;
  logic [3:0]  res_q;
  logic        zero_q;
  logic        wdog_trip;
  logic        ir_unused;

  logic [2:0] op;
  logic [1:0] rd;
  logic [3:0] imm;
  assign op  = ir[15:13];
  assign rd  = ir[11:10];
  assign imm = ir[3:0];
  assign ir_unused = ^ir[5:4];

  assign busy      = (state == S_FETCH) || (state == S_EXEC) || (state == S_WRITE);
  assign dbg_state = state;
  assign dbg_data  = regs[dbg_sel];

  assign alu.alu_a      = regs[ir[9:8]];
  assign alu.alu_b      = regs[ir[7:6]];
  assign alu.alu_opcode = op;

`ifdef ALU_SEQ_WDOG_EN
  logic err_q;
  // Trips on the instruction that would bring the count to the limit, unless it halts anyway.
  assign wdog_trip = (({1'b0, retired} + 9'd1) == {1'b0, WDOG_LIMIT}) && !ir[12];
  assign err = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if ((state == S_IDLE || state == S_HALT) && start) begin
      err_q <= 1'b0;
    end else if (state == S_WRITE && wdog_trip) begin
      err_q <= 1'b1;
    end
  end
`else
  assign wdog_trip = 1'b0;
  assign err       = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE, S_HALT: if (start) state_n = S_FETCH;
      S_FETCH:        state_n = S_EXEC;
      S_EXEC:         state_n = S_WRITE;
      S_WRITE:        state_n = (ir[12] || wdog_trip) ? S_HALT : S_FETCH;
      default:        state_n = S_IDLE;
    endcase
  end

  // The store survives reset so a harness can reload only what changed.
  always_ff @(posedge clk) begin
    if (prog_we && !busy) mem[prog_addr] <= prog_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc      <= 4'd0;
      ir      <= 16'd0;
      regs    <= '{default: 4'd0};
      retired <= 8'd0;
      res_q   <= 4'd0;
      zero_q  <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= (state == S_WRITE) && (state_n == S_HALT);
      case (state)
        S_IDLE, S_HALT: begin
          if (start) begin
            pc      <= 4'd0;
            retired <= 8'd0;
          end
        end
        S_FETCH: ir <= mem[pc];
        S_EXEC: begin
          res_q  <= alu.alu_result;
          zero_q <= alu.alu_zero;
        end
        S_WRITE: begin
          if (op <= 3'd4)      regs[rd] <= res_q;
          else if (op == 3'd7) regs[rd] <= imm;
          // Branches (beq/bne) redirect on the ALU flag; pc wraps naturally at 4 bits.
          if ((op == 3'd5 || op == 3'd6) && zero_q) pc <= imm;
          else                                      pc <= pc + 4'd1;
          if (retired != 8'hFF) retired <= retired + 8'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl with a behavioural ALU on the bus; build with ALU_SEQ_WDOG_EN to cover the watchdog.
module tb_alu_seq_ctrl;
  logic        clk = 1'b0;
  logic        rst, start, prog_we;
  logic [3:0]  prog_addr;
  logic [15:0] prog_data;
  logic [1:0]  dbg_sel;
  logic [3:0]  dbg_data, pc;
  logic        busy, done, err;
  logic [7:0]  retired;
  logic [2:0]  dbg_state;
  int checks = 0;
  int errors = 0;

  alu_seq_if bus ();

  alu_seq_ctrl #(.WDOG_LIMIT(8'd10)) dut (
    .clk(clk), .rst(rst), .start(start), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .dbg_sel(dbg_sel), .dbg_data(dbg_data), .alu(bus),
    .pc(pc), .busy(busy), .done(done), .retired(retired), .err(err), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Reference ALU: flag is the branch condition for beq/bne, otherwise result==0.
  always_comb begin
    case (bus.alu_opcode)
      3'd0:    bus.alu_result = bus.alu_a + bus.alu_b;
      3'd1:    bus.alu_result = bus.alu_a - bus.alu_b;
      3'd2:    bus.alu_result = bus.alu_a & bus.alu_b;
      3'd3:    bus.alu_result = bus.alu_a | bus.alu_b;
      3'd4:    bus.alu_result = {3'b000, bus.alu_a < bus.alu_b};
      default: bus.alu_result = 4'd0;
    endcase
    case (bus.alu_opcode)
      3'd5:    bus.alu_zero = (bus.alu_a == bus.alu_b);
      3'd6:    bus.alu_zero = (bus.alu_a != bus.alu_b);
      default: bus.alu_zero = (bus.alu_result == 4'd0);
    endcase
  end

  function automatic logic [15:0] ins(input logic [2:0] op, input logic h, input logic [1:0] rd,
                                      input logic [1:0] rs, input logic [1:0] rt, input logic [3:0] imm);
    return {op, h, rd, rs, rt, 2'b00, imm};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_reg(input string tag, input logic [1:0] idx, input logic [3:0] exp);
    dbg_sel = idx;
    #1;
    check(tag, dbg_data, exp);
  endtask

  task automatic load(input logic [3:0] addr, input logic [15:0] data);
    @(negedge clk);
    prog_we = 1'b1; prog_addr = addr; prog_data = data;
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  // Pulses start (optionally with a store write on the same edge) and waits for done, bounded.
  task automatic run(input logic w_en, input logic [3:0] w_addr, input logic [15:0] w_data,
                     input int max_cyc, output int done_cyc, output int busy_cnt);
    done_cyc = 0;
    busy_cnt = 0;
    @(negedge clk);
    start = 1'b1; prog_we = w_en; prog_addr = w_addr; prog_data = w_data;
    @(negedge clk);
    start = 1'b0; prog_we = 1'b0;
    for (int k = 1; k <= max_cyc; k++) begin
      if (busy) busy_cnt++;
      if (done) begin
        done_cyc = k;
        break;
      end
      @(negedge clk);
    end
  endtask

  int dc, bc, seen;

  initial begin
    rst = 1'b1; start = 1'b0; prog_we = 1'b0; prog_addr = 4'd0; prog_data = 16'd0; dbg_sel = 2'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_state", dbg_state, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_pc", pc, 0);
    check("rst_retired", retired, 0);
    check("rst_opcode", bus.alu_opcode, 0);
    check("rst_alu_a", bus.alu_a, 0);
    check_reg("rst_r3", 2'd3, 4'd0);

    // ldi r1,5; ldi r2,3; add r3=r1+r2 (halt); word 0 written on the start edge
    load(4'd1, ins(3'd7, 1'b0, 2'd2, 2'd0, 2'd0, 4'd3));
    load(4'd2, ins(3'd0, 1'b1, 2'd3, 2'd1, 2'd2, 4'd0));
    run(1'b1, 4'd0, ins(3'd7, 1'b0, 2'd1, 2'd0, 2'd0, 4'd5), 20, dc, bc);
    check("add_done_cyc", dc, 10);
    check("add_busy_cycles", bc, 9);
    check("add_retired", retired, 3);
    check("add_pc", pc, 3);
    check("add_state", dbg_state, 4);
    check_reg("add_r1", 2'd1, 4'd5);
    check_reg("add_r3", 2'd3, 4'd8);
    @(negedge clk);
    check("done_pulse_one", done, 0);
    check("halt_busy", busy, 0);

    // beq / bne at pc 0 with r1=r2=2
    load(4'd0, ins(3'd7, 1'b0, 2'd1, 2'd0, 2'd0, 4'd2));
    load(4'd1, ins(3'd7, 1'b1, 2'd2, 2'd0, 2'd0, 4'd2));
    run(1'b0, 4'd0, 16'd0, 20, dc, bc);
    check("setup22_done", dc, 7);
    run(1'b1, 4'd0, ins(3'd5, 1'b1, 2'd0, 2'd1, 2'd2, 4'd6), 20, dc, bc);
    check("beq_done", dc, 4);
    check("beq_pc", pc, 6);
    check("beq_retired", retired, 1);
    run(1'b1, 4'd0, ins(3'd6, 1'b1, 2'd0, 2'd1, 2'd2, 4'd6), 20, dc, bc);
    check("bne_pc", pc, 1);

    // Branch to 15, ldi there with halt; pc wraps to 0
    load(4'd15, ins(3'd7, 1'b1, 2'd0, 2'd0, 2'd0, 4'd4));
    run(1'b1, 4'd0, ins(3'd5, 1'b0, 2'd0, 2'd1, 2'd1, 4'd15), 20, dc, bc);
    check("wrap_done", dc, 7);
    check("wrap_pc", pc, 0);
    check_reg("wrap_r0", 2'd0, 4'd4);

    // slt both orders with r1=9, r2=3
    load(4'd1, ins(3'd7, 1'b0, 2'd2, 2'd0, 2'd0, 4'd3));
    load(4'd2, ins(3'd4, 1'b1, 2'd3, 2'd1, 2'd2, 4'd0));
    run(1'b1, 4'd0, ins(3'd7, 1'b0, 2'd1, 2'd0, 2'd0, 4'd9), 20, dc, bc);
    check_reg("slt_9_3", 2'd3, 4'd0);
    run(1'b1, 4'd2, ins(3'd4, 1'b1, 2'd3, 2'd2, 2'd1, 4'd0), 20, dc, bc);
    check_reg("slt_3_9", 2'd3, 4'd1);

    // sub/and/or with r1=9, r2=3
    load(4'd1, ins(3'd2, 1'b0, 2'd3, 2'd1, 2'd2, 4'd0));
    load(4'd2, ins(3'd3, 1'b1, 2'd2, 2'd1, 2'd2, 4'd0));
    run(1'b1, 4'd0, ins(3'd1, 1'b0, 2'd0, 2'd1, 2'd2, 4'd0), 20, dc, bc);
    check("ops_done", dc, 10);
    check_reg("sub_r0", 2'd0, 4'd6);
    check_reg("and_r3", 2'd3, 4'd1);
    check_reg("or_r2", 2'd2, 4'd11);

    // start and prog_we while busy are ignored
    load(4'd0, ins(3'd7, 1'b0, 2'd1, 2'd0, 2'd0, 4'd1));
    load(4'd1, ins(3'd7, 1'b0, 2'd2, 2'd0, 2'd0, 4'd2));
    load(4'd2, ins(3'd0, 1'b1, 2'd3, 2'd1, 2'd2, 4'd0));
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dc = 0;
    for (int k = 1; k <= 12; k++) begin
      prog_we   = (k >= 2 && k <= 8);
      prog_addr = 4'd2;
      prog_data = ins(3'd7, 1'b1, 2'd3, 2'd0, 2'd0, 4'd15);
      start     = (k == 4);
      if (done && dc == 0) dc = k;
      @(negedge clk);
    end
    prog_we = 1'b0; start = 1'b0;
    check("busy_ign_done", dc, 10);
    check("busy_ign_retired", retired, 3);
    check_reg("busy_ign_r3", 2'd3, 4'd3);
    load(4'd3, 16'd0);
    check_reg("busy_ign_r3_clear", 2'd3, 4'd3);
    run(1'b0, 4'd0, 16'd0, 20, dc, bc);
    check("rerun_done", dc, 10);
    check_reg("rerun_r3", 2'd3, 4'd3);

    // Reset in EXEC of add targeting r3 (r3=7 first)
    load(4'd0, ins(3'd7, 1'b1, 2'd3, 2'd0, 2'd0, 4'd7));
    run(1'b0, 4'd0, 16'd0, 20, dc, bc);
    check_reg("pre_rst_r3", 2'd3, 4'd7);
    load(4'd0, ins(3'd0, 1'b1, 2'd3, 2'd1, 2'd2, 4'd0));
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("mid_fetch_state", dbg_state, 1);
    @(negedge clk);
    check("mid_exec_state", dbg_state, 2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_state", dbg_state, 0);
    check("mid_rst_pc", pc, 0);
    check("mid_rst_opcode", bus.alu_opcode, 0);
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      if (done || busy) seen++;
      @(negedge clk);
    end
    check("mid_rst_quiet", seen, 0);
    check_reg("mid_rst_r3", 2'd3, 4'd0);

    // bne-to-self with r1 != r2
    load(4'd0, ins(3'd7, 1'b0, 2'd1, 2'd0, 2'd0, 4'd1));
    load(4'd1, ins(3'd7, 1'b1, 2'd2, 2'd0, 2'd0, 4'd2));
    run(1'b0, 4'd0, 16'd0, 20, dc, bc);
    check("wd_setup_done", dc, 7);
    load(4'd0, ins(3'd6, 1'b0, 2'd0, 2'd1, 2'd2, 4'd0));
`ifdef ALU_SEQ_WDOG_EN
    run(1'b0, 4'd0, 16'd0, 60, dc, bc);
    check("wd_done_cyc", dc, 31);
    check("wd_busy_cycles", bc, 30);
    check("wd_err", err, 1);
    check("wd_retired", retired, 10);
    check("wd_pc", pc, 0);
    @(negedge clk);
    check("wd_err_hold", err, 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("wd_err_clear", err, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
`else
    run(1'b0, 4'd0, 16'd0, 1000, dc, bc);
    check("nowd_no_done", dc, 0);
    check("nowd_busy", busy, 1);
    check("nowd_err", err, 0);
    check("nowd_retired_sat", retired, 255);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("nowd_rst_busy", busy, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got %0d expected %0d", 1, 0);
    $fatal(1, "bench did not terminate");
  end
endmodule
